// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and decode handoff.
// master = fetch stage, slave = surrounding memory/execute/decode environment.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_instr;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output d_valid,
        output d_pc,
        output d_instr,
        input  d_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  d_valid,
        input  d_pc,
        input  d_instr,
        output d_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Generic FIFO with flush and occupancy count; head readable the cycle after push.
// No internal backpressure: the owner must never push when full or pop when empty.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_vld) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push_vld) - CNT_W'(pop_vld);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push_vld && !pop_vld && !flush && count_q == CNT_W'(DEPTH)));
    underflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(pop_vld && !flush && count_q == '0));
endmodule

// Fetch stage: PC owner issuing word requests and tagging responses with their PC for decode.
// Response-to-decode latency 1 cycle; requests are credit-limited by in-flight plus buffered <= DEPTH.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             credit_ok;
    logic             req_fire;
    logic             rsp_keep;
    logic             d_fire;

    logic [31:0]      pcq_head;
    logic             pcq_empty;
    logic [CNT_W-1:0] pcq_count;

    fetch_pkt_t       ofifo_in;
    fetch_pkt_t       ofifo_head;
    logic             ofifo_empty;
    logic [CNT_W-1:0] ofifo_count;

    // Credit counts only current occupancy, so a same-cycle pop does not free a slot early.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, ofifo_count}) < DEPTH_C;

    assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_keep = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == '0);
    assign ofifo_in = {pcq_head, bus.imem_rsp_data};

    assign bus.d_valid = !ofifo_empty && !bus.redirect_valid;
    assign bus.d_pc    = ofifo_head.pc;
    assign bus.d_instr = ofifo_head.instr;
    assign d_fire      = bus.d_valid && bus.d_ready;

    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
        if (bus.redirect_valid) begin
            pc_d   = bus.redirect_pc & 32'hFFFF_FFFC;
            // Everything still outstanding after this cycle belongs to the old path.
            drop_d = inflight_q - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (bus.imem_rsp_valid && drop_q != '0) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Addresses of accepted requests; the queue is never flushed since every request gets a response.
    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push_vld (req_fire),
        .push_dat (pc_q),
        .pop_vld  (bus.imem_rsp_valid),
        .head_dat (pcq_head),
        .empty    (pcq_empty),
        .count    (pcq_count)
    );

    fetch_fifo #(.WIDTH($bits(fetch_pkt_t)), .DEPTH(DEPTH)) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.redirect_valid),
        .push_vld (rsp_keep),
        .push_dat (ofifo_in),
        .pop_vld  (d_fire),
        .head_dat (ofifo_head),
        .empty    (ofifo_empty),
        .count    (ofifo_count)
    );

    pcq_tracks_inflight: assert property (@(posedge clk) disable iff (rst)
        pcq_count == inflight_q);
    rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rsp_valid |-> !pcq_empty);
    drop_bounded: assert property (@(posedge clk) disable iff (rst)
        drop_q <= inflight_q);
endmodule
